// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/ready bus between the MEM stage and memory
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_wstrb,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_wstrb,
    output dmem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I MEM stage: load/store over a req/ready data bus, WB feed
module mem_access_unit #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_valid,
  input  logic [31:0]              ex_alu_result,
  input  logic [31:0]              ex_store_data,
  input  logic [4:0]               ex_rd,
  input  logic [2:0]               ex_funct3,
  input  logic                     ex_mem_read,
  input  logic                     ex_mem_write,
  input  logic                     ex_reg_write,
  output logic                     mem_stall,
  mem_access_unit_if.master        dmem,
  output logic                     wb_valid,
  output logic [31:0]              wb_result,
  output logic [4:0]               wb_rd,
  output logic                     wb_reg_write,
  output logic                     mem_exc,
  output logic [1:0]               mem_exc_cause
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // One write-back/exception event headed for the WB slot.
  typedef struct packed {
    logic        valid;
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
  } slot_t;

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  state_t      state;
  logic [7:0]  wait_count;

  // An instruction that completes without memory (ALU op or faulting access)
  // accepted in the same cycle a load/store finishes would collide with that
  // completion in the WB slot; it parks here for one cycle. It can only be
  // occupied while IDLE, so it always drains before the next completion.
  slot_t       held;

  // Context of the outstanding access, used to shape the completion.
  logic [2:0]  pend_funct3;
  logic [1:0]  pend_offset;
  logic [4:0]  pend_rd;
  logic        pend_reg_write;
  logic        pend_load;

  logic        is_mem;
  logic        illegal;
  logic        misaligned;
  logic        issue;
  logic        accept;
  logic        completion;
  logic [31:0] store_wdata;
  logic [3:0]  store_wstrb;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  slot_t       new_slot;
  slot_t       comp_slot;
  slot_t       out_slot;
  slot_t       next_held;

  // Upstream is held only while waiting; a ready cycle frees EX immediately.
  assign mem_stall  = (state == S_WAIT) && !dmem.dmem_ready;
  assign accept     = !mem_stall;
  assign completion = (state == S_WAIT) && dmem.dmem_ready;

  // Classify the EX instruction and format store lanes.
  always_comb begin
    is_mem  = ex_mem_read || ex_mem_write;
    illegal = (ex_mem_read && ex_mem_write)
           || (ex_mem_read && ((ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11)))
           || (ex_mem_write && (ex_funct3 >= 3'b011));
    misaligned = ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0])
              || ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));
    issue = ex_valid && is_mem && !illegal && !misaligned;

    store_wdata = ex_store_data;
    store_wstrb = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        store_wdata = {4{ex_store_data[7:0]}};
        store_wstrb = 4'b0001 << ex_alu_result[1:0];
      end
      2'b01: begin
        store_wdata = {2{ex_store_data[15:0]}};
        store_wstrb = 4'b0011 << {ex_alu_result[1], 1'b0};
      end
      default: ;
    endcase

    new_slot           = '0;
    new_slot.valid     = ex_valid && !issue;
    new_slot.exc       = ex_valid && is_mem && !issue;
    new_slot.cause     = illegal ? 2'b10 : 2'b01;
    new_slot.result    = ex_alu_result;
    new_slot.rd        = ex_rd;
    new_slot.reg_write = ex_reg_write && (ex_rd != 5'd0) && !is_mem;
  end

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    lane_byte = 8'(dmem.dmem_rdata >> {pend_offset, 3'b000});
    lane_half = pend_offset[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (pend_funct3)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'd0, lane_byte};
      3'b101:  load_data = {16'd0, lane_half};
      default: load_data = dmem.dmem_rdata;
    endcase

    comp_slot           = '0;
    comp_slot.valid     = 1'b1;
    comp_slot.result    = pend_load ? load_data : 32'd0;
    comp_slot.rd        = pend_rd;
    comp_slot.reg_write = pend_reg_write;
  end

  // Pick what enters the WB slot on an accepting edge: memory completion first,
  // then a parked instruction, then the newly accepted one.
  always_comb begin
    if (completion) begin
      out_slot  = comp_slot;
      next_held = new_slot;
    end else if (held.valid) begin
      out_slot  = held;
      next_held = new_slot;
    end else begin
      out_slot  = new_slot;
      next_held = '0;
    end
  end

  // Access FSM with registered bus, WB and exception outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      wait_count       <= 8'd0;
      held             <= '0;
      pend_funct3      <= 3'd0;
      pend_offset      <= 2'd0;
      pend_rd          <= 5'd0;
      pend_reg_write   <= 1'b0;
      pend_load        <= 1'b0;
      dmem.dmem_req    <= 1'b0;
      dmem.dmem_we     <= 1'b0;
      dmem.dmem_addr   <= 32'd0;
      dmem.dmem_wdata  <= 32'd0;
      dmem.dmem_wstrb  <= 4'd0;
      wb_valid         <= 1'b0;
      wb_result        <= 32'd0;
      wb_rd            <= 5'd0;
      wb_reg_write     <= 1'b0;
      mem_exc          <= 1'b0;
      mem_exc_cause    <= 2'd0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      mem_exc      <= 1'b0;

      if (accept) begin
        if (out_slot.valid) begin
          wb_valid     <= !out_slot.exc;
          wb_result    <= out_slot.result;
          wb_rd        <= out_slot.rd;
          wb_reg_write <= !out_slot.exc && out_slot.reg_write;
          mem_exc      <= out_slot.exc;
          if (out_slot.exc) begin
            mem_exc_cause <= out_slot.cause;
          end
        end
        held       <= next_held;
        wait_count <= 8'd0;

        if (issue) begin
          state            <= S_WAIT;
          dmem.dmem_req    <= 1'b1;
          dmem.dmem_we     <= ex_mem_write;
          dmem.dmem_addr   <= {ex_alu_result[31:2], 2'b00};
          dmem.dmem_wdata  <= ex_mem_write ? store_wdata : 32'd0;
          dmem.dmem_wstrb  <= ex_mem_write ? store_wstrb : 4'd0;
          pend_funct3      <= ex_funct3;
          pend_offset      <= ex_alu_result[1:0];
          pend_rd          <= ex_rd;
          pend_reg_write   <= ex_mem_read && ex_reg_write && (ex_rd != 5'd0);
          pend_load        <= ex_mem_read;
        end else begin
          state         <= S_IDLE;
          dmem.dmem_req <= 1'b0;
          dmem.dmem_we  <= 1'b0;
        end
      end else if (wait_count == LAST_WAIT) begin
        // Memory never answered: abandon the access and report it.
        state         <= S_IDLE;
        wait_count    <= 8'd0;
        dmem.dmem_req <= 1'b0;
        dmem.dmem_we  <= 1'b0;
        mem_exc       <= 1'b1;
        mem_exc_cause <= 2'b11;
      end else begin
        wait_count <= wait_count + 8'd1;
      end
    end
  end

endmodule
